// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-entry layout used by the RX FIFO and host register block.
package uart_pkg;

   localparam int UART_WIDTH    = 8;
   localparam int RX_FIFO_DEPTH = 16;

   typedef struct packed {
      logic                  parity_err;
      logic                  stop_err;
      logic [UART_WIDTH-1:0] data;
   } rx_entry_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous (combinational) read.
module uart_fifo_mem #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // NOTE: storage is deliberately not reset; the pointers decide which entries are live.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver with a sticky overflow flag.
// Define UART_RX_FIFO_ERR_DROP_EN to discard errored frames and add the err_drop pulse output.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH   = UART_WIDTH,
   parameter int DEPTH   = RX_FIFO_DEPTH,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_parity_err,
   input  logic             in_stop_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_parity_err,
   output logic             out_stop_err,
   output logic [AW:0]      count,
   output logic             full,
   output logic             overflow,
   input  logic             clr_overflow
`ifdef UART_RX_FIFO_ERR_DROP_EN
   ,
   output logic             err_drop
`endif
);

   localparam int EW = WIDTH + 2;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic          w_frame_ok;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [EW-1:0] w_wr_entry;
   logic [EW-1:0] w_rd_entry;

`ifdef UART_RX_FIFO_ERR_DROP_EN
   logic r_err_drop;
   assign w_frame_ok = ~(in_parity_err | in_stop_err);
   assign err_drop   = r_err_drop;
`else
   assign w_frame_ok = 1'b1;
`endif

   assign w_full = (r_count == FULL_CNT);
   assign w_pop  = out_valid & out_ready;

   // A full FIFO still accepts a frame when the head leaves in the same cycle.
   assign w_push = in_valid & w_frame_ok & (~w_full | w_pop) & ~rst;
   assign w_drop = in_valid & w_frame_ok & w_full & ~w_pop;

   assign w_wr_entry = {in_parity_err, in_stop_err, in_data};

   uart_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_entry)
   );

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A new drop wins over a simultaneous clear.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

`ifdef UART_RX_FIFO_ERR_DROP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_drop <= 1'b0;
      end else begin
         r_err_drop <= in_valid & ~w_frame_ok;
      end
   end
`endif

   assign out_valid      = (r_count != '0);
   assign out_data       = out_valid ? w_rd_entry[WIDTH-1:0] : '0;
   assign out_stop_err   = out_valid & w_rd_entry[WIDTH];
   assign out_parity_err = out_valid & w_rd_entry[WIDTH+1];
   assign count          = r_count;
   assign full           = w_full;
   assign overflow       = r_overflow;

endmodule : uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It captures each completed frame as one entry: the data byte plus its parity and stop error flags. The entry is written on a one-cycle frame-done strobe from the receiver FSM. Entries are presented to the host/bus side through a show-ahead valid/ready interface, which decouples serial arrival from host read latency. Overflow is tracked with a sticky flag.

Parameters:
- WIDTH, 8, data bits per frame; matches the receiver's WIDTH.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  one-cycle strobe: frame complete, in_data and the error flags are valid.
- in_data  input  WIDTH  received byte (receiver data output).
- in_parity_err  input  1  parity error flag for this frame.
- in_stop_err  input  1  stop-bit error flag for this frame.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_data  output  WIDTH  head entry data.
- out_parity_err  output  1  head entry parity error flag.
- out_stop_err  output  1  head entry stop error flag.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a frame was dropped.
- clr_overflow  input  1  clears overflow.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Therefore out_valid=0 and full=0.
  - Storage array is not reset.
  - Reset mid-operation discards all stored entries; any in_valid in the reset cycle is ignored.
- Entry format: {parity_err, stop_err, data}, WIDTH+2 bits.
- Write: occurs when in_valid=1 and (full=0 or pop this cycle).
  - Stores the entry at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Pop: occurs when out_valid=1 and out_ready=1.
  - rd_ptr increments and wraps modulo DEPTH.
  - out_ready while out_valid=0 has no effect.
- Show-ahead read:
  - out_valid = (count != 0).
  - out_* driven combinationally from mem[rd_ptr].
  - out_data, out_parity_err and out_stop_err are forced to 0 when out_valid=0.
- Latency: an entry written at edge N is visible (out_valid=1) after edge N. There is no same-cycle bypass while empty.
- count update: +1 on write only, -1 on pop only, unchanged on both or neither.
- Full and push without pop: entry dropped, state unchanged, overflow set to 1 at that edge.
- Full and push with pop: both happen; count stays at DEPTH and overflow is not set.
- Empty and push: write only (pop impossible); count 0 -> 1.
- Overflow clearing:
  - overflow holds until clr_overflow=1.
  - If clr_overflow and a new drop occur in the same cycle, overflow = 1 (set wins).
- Flags never alter the data path: an errored frame is stored like a good one (unless the optional feature is enabled).
- No state machine beyond the pointer/count registers.
- Pointer wrap: after DEPTH writes and DEPTH pops, both pointers return to 0 with no loss.

Optional Feature:
Macro UART_RX_FIFO_ERR_DROP_EN.
- Defined:
  - A frame with in_parity_err=1 or in_stop_err=1 is not written, and does not set overflow.
  - An extra output port err_drop (1 bit) pulses for one cycle, the cycle after each such discarded frame.
- Undefined: all frames are stored, and the err_drop port does not exist.

Decomposition:
- Package uart_pkg holds:
  - UART_WIDTH = 8
  - RX_FIFO_DEPTH = 16
  - typedef rx_entry_t = {parity_err, stop_err, data[WIDTH-1:0]}, reused by the host-side register block.
- One natural sub-module: uart_fifo_mem. It is a DEPTH x (WIDTH+2) register array with synchronous write and asynchronous read, instantiated once.
- Pointer, count and flag logic stay in the top.

Test Plan:
- Reset, then push 0xA5 (flags 0) with out_ready=0.
  - Next cycle: out_valid=1, out_data=0xA5, count=1.
  - Assert out_ready: out_valid=0 and count=0 next cycle.
- Push 16 frames 0x00..0x0F, then a 17th frame 0xFF with out_ready=0.
  - full=1, overflow=1.
  - Subsequent pops return 0x00..0x0F in order; 0xFF is never output.
- While full, push 0x55 with out_ready=1 in the same cycle.
  - 0x00 popped, count stays 16, overflow stays 0.
  - 0x55 emerges after 0x0F.
- Push 0x3C with in_parity_err=1, then 0x7E with in_stop_err=1.
  - Flags are read back in order: (1,0) then (0,1).
  - With UART_RX_FIFO_ERR_DROP_EN defined: count stays 0 and err_drop pulses twice.
- 40 pushes and pops with random out_ready, exercising pointer wrap.
  - Scoreboard matches the in-order sequence; count never exceeds 16.
- Fill 5 entries, assert rst for 1 cycle together with in_valid.
  - count=0, out_valid=0, overflow=0 after the edge.
- Set overflow, then assert clr_overflow together with a new drop.
  - overflow remains 1.
- Assert clr_overflow alone: overflow becomes 0.
